// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and step-counter sizing.
package divisor_pkg;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] CALCULA = 2'd1;
    localparam logic [1:0] FIM     = 2'd2;

    localparam int unsigned WIDTH_PADRAO = 4;

    // Step counter only has to reach WIDTH-1.
    function automatic int unsigned largura_contador(input int unsigned w);
        return $clog2(w);
    endfunction

    localparam int unsigned CNT_W = largura_contador(WIDTH_PADRAO);

endpackage

// File: rtl/subtrator_passo.sv
// Combinational trial subtractor for one restoring-division step; the
// subtract counterpart of the 4-bit adder.
module subtrator_passo #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diferenca_c,
    output logic         emprestimo_c
);

    assign {emprestimo_c, diferenca_c} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/divisor4bits.sv
// Sequential unsigned restoring divider, one trial subtraction per clock,
// with a start/done handshake and divide-by-zero flag.
module divisor4bits
    import divisor_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_PADRAO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic             ocupado,
    output logic             pronto,
    output logic [WIDTH-1:0] quociente,
    output logic [WIDTH-1:0] resto,
    output logic             erro_div0
);

    localparam int unsigned   CW     = largura_contador(WIDTH);
    localparam int unsigned   RW     = WIDTH + 1;
    localparam logic [CW-1:0] ULTIMO = CW'(WIDTH - 1);

    logic [1:0]       estado;
    logic [1:0]       estado_prox;
    logic             ocupado_c;
    logic             pronto_c;
    logic [RW-1:0]    parcial;
    logic [RW-1:0]    parcial_desl;
    logic [RW-1:0]    diferenca;
    logic [RW-1:0]    parcial_prox;
    logic             emprestimo;
    logic [WIDTH-1:0] quoc_sr;
    logic [WIDTH-1:0] quoc_prox;
    logic [WIDTH-1:0] divisor_q;
    logic [CW-1:0]    passo;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO: begin
                if (inicio) begin
                    estado_prox = (divisor == '0) ? FIM : CALCULA;
                end
            end
            CALCULA: begin
                if (passo == ULTIMO) begin
                    estado_prox = FIM;
                end
            end
            FIM:     estado_prox = OCIOSO;
            default: estado_prox = OCIOSO;
        endcase
    end

    // Handshake flags decoded from the next state so they leave a flop.
    always_comb begin
        ocupado_c = 1'b0;
        pronto_c  = 1'b0;
        if (estado_prox != OCIOSO) begin
            ocupado_c = 1'b1;
        end
        if (estado_prox == FIM) begin
            pronto_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ocupado <= 1'b0;
            pronto  <= 1'b0;
        end else begin
            ocupado <= ocupado_c;
            pronto  <= pronto_c;
        end
    end

    // Shift in the next dividend bit; the dropped top bit is always 0
    // because the partial remainder stays below the divisor.
    assign parcial_desl = RW'({parcial, quoc_sr[WIDTH-1]});

    subtrator_passo #(
        .W (RW)
    ) u_subtrator (
        .a            (parcial_desl),
        .b            ({1'b0, divisor_q}),
        .diferenca_c  (diferenca),
        .emprestimo_c (emprestimo)
    );

    assign parcial_prox = emprestimo ? parcial_desl : diferenca;
    assign quoc_prox    = {quoc_sr[WIDTH-2:0], ~emprestimo};

    always_ff @(posedge clk) begin
        if (rst) begin
            parcial   <= '0;
            quoc_sr   <= '0;
            divisor_q <= '0;
            passo     <= '0;
            quociente <= '0;
            resto     <= '0;
            erro_div0 <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        divisor_q <= divisor;
                        erro_div0 <= 1'b0;
                        if (divisor != '0) begin
                            parcial <= '0;
                            quoc_sr <= dividendo;
                            passo   <= '0;
                        end else begin
                            quociente <= '1;
                            resto     <= dividendo;
                            erro_div0 <= 1'b1;
                        end
                    end
                end
                CALCULA: begin
                    parcial <= parcial_prox;
                    quoc_sr <= quoc_prox;
                    passo   <= passo + CW'(1);
                    if (passo == ULTIMO) begin
                        quociente <= quoc_prox;
                        resto     <= parcial_prox[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor4bits.sv
// Directed and exhaustive self-checking bench for the 4-bit restoring divider.
module tb_divisor4bits;

    logic       clk;
    logic       rst;
    logic       inicio;
    logic [3:0] dividendo;
    logic [3:0] divisor;
    logic       ocupado;
    logic       pronto;
    logic [3:0] quociente;
    logic [3:0] resto;
    logic       erro_div0;

    int n_vec;
    int n_err;
    int n_pronto;
    int n_starts;

    divisor4bits #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inicio    (inicio),
        .dividendo (dividendo),
        .divisor   (divisor),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .quociente (quociente),
        .resto     (resto),
        .erro_div0 (erro_div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pronto === 1'b1) n_pronto++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ocupado"}, 32'(ocupado), 0);
        check({tag, " pronto"}, 32'(pronto), 0);
        check({tag, " quociente"}, 32'(quociente), 0);
        check({tag, " resto"}, 32'(resto), 0);
        check({tag, " erro_div0"}, 32'(erro_div0), 0);
    endtask

    // Start a division, scramble operands, then verify latency, busy window and results.
    task automatic run_div(input int a, input int b, input int eq, input int er, input int ee);
        int lat;
        int busy;
        string t;
        t = $sformatf("%0d/%0d", a, b);
        dividendo = 4'(a);
        divisor   = 4'(b);
        inicio    = 1'b1;
        tick();
        n_starts++;
        inicio    = 1'b0;
        dividendo = 4'($urandom);
        divisor   = 4'($urandom);
        lat  = 0;
        busy = 0;
        while (pronto !== 1'b1 && lat < 20) begin
            if (ocupado === 1'b1) busy++;
            tick();
            lat++;
        end
        if (ocupado === 1'b1) busy++;
        check({t, " latency"}, 32'(lat), (b == 0) ? 0 : 4);
        check({t, " ocupado cycles"}, 32'(busy), (b == 0) ? 1 : 5);
        check({t, " quociente"}, 32'(quociente), 32'(eq));
        check({t, " resto"}, 32'(resto), 32'(er));
        check({t, " erro_div0"}, 32'(erro_div0), 32'(ee));
        tick();
        check({t, " pronto pulse end"}, 32'(pronto), 0);
        check({t, " ocupado end"}, 32'(ocupado), 0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (pronto === 1'b1 || ocupado === 1'b1) seen++;
            tick();
        end
        check(tag, 32'(seen), 0);
    endtask

    initial begin
        int lat;
        n_vec     = 0;
        n_err     = 0;
        n_pronto  = 0;
        n_starts  = 0;
        rst       = 1'b1;
        inicio    = 1'b0;
        dividendo = 4'd0;
        divisor   = 4'd0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        run_div(13, 4, 3, 1, 0);
        run_div(15, 1, 15, 0, 0);
        run_div(0, 7, 0, 0, 0);
        run_div(3, 9, 0, 3, 0);
        run_div(9, 0, 15, 9, 1);
        run_div(8, 2, 4, 0, 0);

        // Second request during the computation must be ignored.
        dividendo = 4'd14;
        divisor   = 4'd3;
        inicio    = 1'b1;
        tick();
        inicio = 1'b0;
        tick();
        dividendo = 4'd5;
        divisor   = 4'd5;
        inicio    = 1'b1;
        tick();
        inicio = 1'b0;
        lat = 0;
        while (pronto !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("ignored start latency", 32'(lat), 2);
        check("ignored start quociente", 32'(quociente), 4);
        check("ignored start resto", 32'(resto), 2);
        tick();
        expect_quiet("ignored start no extra op", 10);

        // Reset in the middle of a division aborts it.
        dividendo = 4'd9;
        divisor   = 4'd2;
        inicio    = 1'b1;
        tick();
        inicio = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("abort");
        rst = 1'b0;
        expect_quiet("abort no pronto", 8);

        // Reset and start together: the request is dropped.
        dividendo = 4'd7;
        divisor   = 4'd3;
        inicio    = 1'b1;
        rst       = 1'b1;
        tick();
        inicio = 1'b0;
        rst    = 1'b0;
        expect_quiet("rst+inicio dropped", 8);

        // Exhaustive sweep at minimum spacing.
        n_pronto = 0;
        n_starts = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) run_div(a, b, 15, a, 1);
                else        run_div(a, b, a / b, a % b, 0);
            end
        end
        tick();
        check("pronto count", 32'(n_pronto), 32'(n_starts));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
